// File: rtl/config_usb_framer.sv
// DFU OUT byte-stream framer: hunts the sync header, checks the command byte,
// packs payload MSB-first into config words and drains them through a word FIFO.
module config_usb_framer #(
  parameter int          WORD_BYTES   = 4,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [23:0] SYNC_PATTERN = 24'h00AAFF,
  parameter logic [2:0]  DFU_ALT      = 3'd2
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    dfu_mode_i,
  input  logic [2:0]              dfu_alt_i,
  input  logic [7:0]              dfu_out_data_i,
  input  logic                    dfu_out_valid_i,
  output logic                    dfu_out_ready_o,
  input  logic                    dfu_clear_status_i,
  output logic                    dfu_busy_o,
  output logic [3:0]              dfu_status_o,
  input  logic                    cfg_ready_i,
  output logic                    word_write_strobe_o,
  output logic [8*WORD_BYTES-1:0] write_data_o,
  output logic [15:0]             word_count_o,
  output logic [2:0]              fsm_state_o
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [7:0] HDR0 = SYNC_PATTERN[23:16];
  localparam logic [7:0] HDR1 = SYNC_PATTERN[15:8];
  localparam logic [7:0] HDR2 = SYNC_PATTERN[7:0];

  localparam logic [3:0] STATUS_OK  = 4'h0;
  localparam logic [3:0] STATUS_ERR = 4'h1;

  typedef enum logic [2:0] {
    S_SYNC0 = 3'd0,
    S_SYNC1 = 3'd1,
    S_SYNC2 = 3'd2,
    S_CMD   = 3'd3,
    S_DATA  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [W-1:0]   packer;
  logic [W-1:0]   word_next;
  logic [W-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [3:0]     status;
  logic           strobe;
  logic [W-1:0]   wdata;
  logic [15:0]    count;

  logic active;
  logic last_slot;
  logic fifo_empty;
  logic fifo_full;
  logic acc;
  logic push;
  logic pop;
  logic cmd_ok;

  // Handshake: a byte moves when dfu_out_valid_i && dfu_out_ready_o at a rising
  // clk_i edge; ready drops only on the byte that would complete a word into a full FIFO.
  assign active     = dfu_mode_i && (dfu_alt_i == DFU_ALT);
  assign last_slot  = (idx == IW'(WORD_BYTES - 1));
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dfu_out_ready_o = active && !((state == S_DATA) && last_slot && fifo_full);
  assign acc        = dfu_out_valid_i && dfu_out_ready_o;
  assign push       = acc && (state == S_DATA) && last_slot;
  assign pop        = active && !fifo_empty && cfg_ready_i;
  assign cmd_ok     = (dfu_out_data_i[6:0] == 7'd1) || (dfu_out_data_i[6:0] == 7'd2);

  // Current partial word with the incoming byte dropped into its slot.
  always_comb begin
    word_next = packer;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (idx == IW'(WORD_BYTES - 1 - k)) word_next[8*k +: 8] = dfu_out_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= S_SYNC0;
      idx    <= '0;
      packer <= '0;
      status <= STATUS_OK;
    end else if (!active) begin
      state  <= S_SYNC0;
      idx    <= '0;
      packer <= '0;
    end else begin
      case (state)
        S_SYNC0: if (acc) state <= (dfu_out_data_i == HDR0) ? S_SYNC1 : S_SYNC0;
        S_SYNC1: begin
          if (acc) begin
            if (dfu_out_data_i == HDR1)      state <= S_SYNC2;
            else if (dfu_out_data_i == HDR0) state <= S_SYNC1;
            else                             state <= S_SYNC0;
          end
        end
        S_SYNC2: begin
          if (acc) begin
            if (dfu_out_data_i == HDR2)      state <= S_CMD;
            else if (dfu_out_data_i == HDR0) state <= S_SYNC1;
            else                             state <= S_SYNC0;
          end
        end
        S_CMD: begin
          if (acc) begin
            if (cmd_ok) begin
              state  <= S_DATA;
              idx    <= '0;
              packer <= '0;
            end else begin
              state  <= S_ERROR;
              status <= STATUS_ERR;
            end
          end
        end
        S_DATA: begin
          if (acc) begin
            packer <= last_slot ? '0 : word_next;
            idx    <= last_slot ? '0 : idx + 1'b1;
          end
        end
        S_ERROR: begin
          // Bytes keep flowing and are dropped until the host returns to dfuIDLE.
          if (dfu_clear_status_i) begin
            status <= STATUS_OK;
            state  <= S_SYNC0;
          end
        end
        default: state <= S_SYNC0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word_next;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      strobe <= 1'b0;
      wdata  <= '0;
      count  <= '0;
    end else if (!active) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      strobe <= 1'b0;
      count  <= '0;
    end else begin
      strobe <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        wdata  <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
    end
  end

  assign dfu_busy_o          = !fifo_empty || (idx != '0);
  assign dfu_status_o        = status;
  assign word_write_strobe_o = strobe;
  assign write_data_o        = wdata;
  assign word_count_o        = count;
  assign fsm_state_o         = state;

endmodule

// File: tb/tb_config_usb_framer.sv
// Self-checking bench for config_usb_framer: directed scenarios plus random frames
// scored against a stream-level model (header search, command check, byte grouping).
module tb_config_usb_framer;

  typedef logic [7:0] byte_q_t [$];

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        dfu_mode = 1'b0;
  logic        dfu_mode2 = 1'b0;
  logic [2:0]  dfu_alt = 3'd2;
  logic [7:0]  dfu_out_data = 8'h00;
  logic        dfu_out_valid = 1'b0;
  logic        dfu_clear_status = 1'b0;
  logic        cfg_ready = 1'b1;

  logic        ready, busy, strobe;
  logic [3:0]  status;
  logic [31:0] wdata;
  logic [15:0] count;
  logic [2:0]  fsm_state;

  logic        ready2, busy2, strobe2;
  logic [3:0]  status2;
  logic [15:0] wdata2;
  logic [15:0] count2;
  logic [2:0]  fsm_state2;

  int tests = 0;
  int fails = 0;
  int tgt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] got2_q[$];
  logic        exp_err;
  logic        exp_part;

  config_usb_framer #(.WORD_BYTES(4), .FIFO_DEPTH(16)) u_dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .dfu_mode_i(dfu_mode), .dfu_alt_i(dfu_alt),
    .dfu_out_data_i(dfu_out_data), .dfu_out_valid_i(dfu_out_valid), .dfu_out_ready_o(ready),
    .dfu_clear_status_i(dfu_clear_status), .dfu_busy_o(busy), .dfu_status_o(status),
    .cfg_ready_i(cfg_ready), .word_write_strobe_o(strobe), .write_data_o(wdata),
    .word_count_o(count), .fsm_state_o(fsm_state)
  );

  config_usb_framer #(.WORD_BYTES(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .dfu_mode_i(dfu_mode2), .dfu_alt_i(dfu_alt),
    .dfu_out_data_i(dfu_out_data), .dfu_out_valid_i(dfu_out_valid), .dfu_out_ready_o(ready2),
    .dfu_clear_status_i(dfu_clear_status), .dfu_busy_o(busy2), .dfu_status_o(status2),
    .cfg_ready_i(cfg_ready), .word_write_strobe_o(strobe2), .write_data_o(wdata2),
    .word_count_o(count2), .fsm_state_o(fsm_state2)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    if (strobe)  got_q.push_back(wdata);
    if (strobe2) got2_q.push_back(wdata2);
  end

  // Reference model: first occurrence of 00 AA FF, then the command byte, then
  // whole 4-byte groups of payload, most significant byte first.
  function automatic void run_model(input byte_q_t s);
    int h;
    int n;
    h = -1;
    exp_q.delete();
    exp_err = 1'b0;
    exp_part = 1'b0;
    for (int i = 0; i + 2 < s.size(); i++) begin
      if (s[i] == 8'h00 && s[i+1] == 8'hAA && s[i+2] == 8'hFF) begin
        h = i;
        break;
      end
    end
    if (h < 0 || h + 3 >= s.size()) return;
    if (s[h+3][6:0] != 7'd1 && s[h+3][6:0] != 7'd2) begin
      exp_err = 1'b1;
      return;
    end
    n = s.size() - (h + 4);
    for (int k = 0; k < n / 4; k++) begin
      exp_q.push_back({s[h+4+4*k], s[h+5+4*k], s[h+6+4*k], s[h+7+4*k]});
    end
    exp_part = (n % 4) != 0;
  endfunction

  // Driver tasks: called just after a falling edge, return just after the falling
  // edge that follows the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    dfu_out_data = b;
    dfu_out_valid = 1'b1;
    #1;
    while (!(tgt == 1 ? ready2 : ready) && n < 500) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL send_byte_timeout: ready stayed 0 for %0d cycles, required 1", n);
    end
    @(negedge clk_i);
    dfu_out_valid = 1'b0;
  endtask

  task automatic send_stream(input byte_q_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic flush();
    @(negedge clk_i);
    dfu_mode = 1'b0;
    @(negedge clk_i);
    dfu_mode = 1'b1;
    got_q.delete();
  endtask

  task automatic wait_words(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    if (got_q.size() < n) begin
      tests++;
      fails++;
      $display("FAIL wait_words_timeout: got %0d words, required %0d", got_q.size(), n);
    end
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_reset();
    tests += 7;
    if (ready !== 1'b0)   begin fails++; $display("FAIL reset_ready: got %b, required 0", ready); end
    if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (status !== 4'h0)  begin fails++; $display("FAIL reset_status: got %h, required 0", status); end
    if (strobe !== 1'b0)  begin fails++; $display("FAIL reset_strobe: got %b, required 0", strobe); end
    if (wdata !== 32'h0)  begin fails++; $display("FAIL reset_data: got %h, required 0", wdata); end
    if (count !== 16'h0)  begin fails++; $display("FAIL reset_count: got %0d, required 0", count); end
    if (fsm_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d, required 0", fsm_state); end
  endtask

  task automatic test_basic();
    byte_q_t s;
    s = '{8'h00, 8'hAA, 8'hFF, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    flush();
    cfg_ready = 1'b1;
    run_model(s);
    for (int i = 0; i < 8; i++) send_byte(s[i]);
    tests++;
    if (strobe !== 1'b0) begin fails++; $display("FAIL basic_latency_early: strobe %b, required 0", strobe); end
    @(negedge clk_i);
    tests += 2;
    if (strobe !== 1'b1) begin fails++; $display("FAIL basic_latency: strobe %b, required 1", strobe); end
    if (wdata !== exp_q[0]) begin fails++; $display("FAIL basic_first_word: got %h, required %h", wdata, exp_q[0]); end
    for (int i = 8; i < 12; i++) send_byte(s[i]);
    wait_words(2, 50);
    tests++;
    if (got_q.size() != 2) begin fails++; $display("FAIL basic_word_total: got %0d, required 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    tests += 4;
    if (count !== 16'd2)   begin fails++; $display("FAIL basic_count: got %0d, required 2", count); end
    if (status !== 4'h0)   begin fails++; $display("FAIL basic_status: got %h, required 0", status); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL basic_busy: got %b, required 0", busy); end
    if (wdata !== 32'h12345678) begin fails++; $display("FAIL basic_hold: got %h, required 12345678", wdata); end
  endtask

  task automatic test_error();
    byte_q_t s;
    flush();
    s = '{8'h00, 8'hAA, 8'hFF, 8'h05};
    send_stream(s);
    tests++;
    if (status !== 4'h1) begin fails++; $display("FAIL error_status: got %h, required 1", status); end
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
    repeat (4) @(negedge clk_i);
    tests += 3;
    if (got_q.size() != 0) begin fails++; $display("FAIL error_discard: got %0d words, required 0", got_q.size()); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL error_busy: got %b, required 0", busy); end
    if (status !== 4'h1)   begin fails++; $display("FAIL error_status_held: got %h, required 1", status); end
    dfu_clear_status = 1'b1;
    @(negedge clk_i);
    dfu_clear_status = 1'b0;
    tests++;
    if (status !== 4'h0) begin fails++; $display("FAIL error_clear: got %h, required 0", status); end
    s = '{8'h00, 8'hAA, 8'hFF, 8'h02};
    for (int i = 0; i < 8; i++) s.push_back(8'($urandom_range(0, 255)));
    run_model(s);
    send_stream(s);
    wait_words(2, 50);
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL error_recover_total: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL error_recover_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_resync();
    byte_q_t s;
    flush();
    s = '{8'h00, 8'h00, 8'hAA, 8'hFF, 8'h02};
    for (int i = 0; i < 4; i++) s.push_back(8'($urandom_range(0, 255)));
    run_model(s);
    send_stream(s);
    wait_words(1, 50);
    tests += 2;
    if (got_q.size() != 1) begin fails++; $display("FAIL resync_total: got %0d, required 1", got_q.size()); end
    if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin
      fails++; $display("FAIL resync_word: got %h, required %h", got_q[0], exp_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t s;
    flush();
    cfg_ready = 1'b0;
    s = '{8'h00, 8'hAA, 8'hFF, 8'h01};
    for (int i = 0; i < 17 * 4; i++) s.push_back(8'($urandom_range(0, 255)));
    run_model(s);
    for (int i = 0; i < s.size() - 1; i++) send_byte(s[i]);
    dfu_out_data = s[s.size()-1];
    dfu_out_valid = 1'b1;
    #1;
    tests += 2;
    if (ready !== 1'b0) begin fails++; $display("FAIL full_stall: ready %b, required 0", ready); end
    if (got_q.size() != 0) begin fails++; $display("FAIL full_no_drain: got %0d words, required 0", got_q.size()); end
    repeat (3) @(negedge clk_i);
    #1;
    tests += 2;
    if (ready !== 1'b0) begin fails++; $display("FAIL full_stall_held: ready %b, required 0", ready); end
    if (busy !== 1'b1)  begin fails++; $display("FAIL full_busy: got %b, required 1", busy); end
    cfg_ready = 1'b1;
    send_byte(s[s.size()-1]);
    wait_words(17, 100);
    tests += 2;
    if (got_q.size() != 17) begin fails++; $display("FAIL full_total: got %0d, required 17", got_q.size()); end
    if (count !== 16'd17)   begin fails++; $display("FAIL full_count: got %0d, required 17", count); end
    for (int i = 0; i < 17 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL full_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_alt_flush();
    byte_q_t s;
    flush();
    s = '{8'h00, 8'hAA, 8'hFF, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(s);
    wait_words(1, 50);
    tests += 2;
    if (busy !== 1'b1)   begin fails++; $display("FAIL alt_partial_busy: got %b, required 1", busy); end
    if (count !== 16'd1) begin fails++; $display("FAIL alt_pre_count: got %0d, required 1", count); end
    dfu_alt = 3'd0;
    #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL alt_ready: got %b, required 0", ready); end
    @(negedge clk_i);
    tests += 2;
    if (busy !== 1'b0)   begin fails++; $display("FAIL alt_flush_busy: got %b, required 0", busy); end
    if (count !== 16'd0) begin fails++; $display("FAIL alt_flush_count: got %0d, required 0", count); end
    dfu_alt = 3'd2;
    got_q.delete();
    s = '{8'h77, 8'h88, 8'h99, 8'hBB};
    send_stream(s);
    repeat (6) @(negedge clk_i);
    tests += 2;
    if (got_q.size() != 0) begin fails++; $display("FAIL alt_needs_header: got %0d words, required 0", got_q.size()); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL alt_no_pack: busy %b, required 0", busy); end
    s = '{8'h00, 8'hAA, 8'hFF, 8'h01, 8'hC0, 8'hFF, 8'hEE, 8'h01};
    send_stream(s);
    wait_words(1, 50);
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 32'hC0FFEE01) begin
      fails++; $display("FAIL alt_reheader: got %0d words first %h, required 1 word c0ffee01",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0);
    end
  endtask

  task automatic test_random();
    byte_q_t s;
    logic [7:0] cmds[7];
    logic [7:0] pick[4];
    cmds = '{8'h01, 8'h02, 8'h81, 8'h82, 8'h05, 8'h00, 8'h7F};
    for (int it = 0; it < 10; it++) begin
      flush();
      cfg_ready = 1'($urandom_range(0, 1));
      s.delete();
      pick = '{8'h00, 8'hAA, 8'hFF, 8'($urandom_range(0, 255))};
      for (int i = 0; i < $urandom_range(0, 5); i++) s.push_back(pick[$urandom_range(0, 3)]);
      s.push_back(8'h00); s.push_back(8'hAA); s.push_back(8'hFF);
      s.push_back(cmds[$urandom_range(0, 6)]);
      for (int i = 0; i < $urandom_range(0, 13); i++) s.push_back(8'($urandom_range(0, 255)));
      run_model(s);
      send_stream(s);
      cfg_ready = 1'b1;
      wait_words(exp_q.size(), 60);
      tests += 4;
      if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_total: got %0d, required %0d", it, got_q.size(), exp_q.size()); end
      if (count !== 16'(exp_q.size())) begin fails++; $display("FAIL rand%0d_count: got %0d, required %0d", it, count, exp_q.size()); end
      if (status !== {3'b000, exp_err}) begin fails++; $display("FAIL rand%0d_status: got %h, required %h", it, status, exp_err); end
      if (busy !== exp_part) begin fails++; $display("FAIL rand%0d_busy: got %b, required %b", it, busy, exp_part); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_word%0d: got %h, required %h", it, i, got_q[i], exp_q[i]); end
      end
      if (exp_err) begin
        dfu_clear_status = 1'b1;
        @(negedge clk_i);
        dfu_clear_status = 1'b0;
        tests++;
        if (status !== 4'h0) begin fails++; $display("FAIL rand%0d_clear: got %h, required 0", it, status); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    byte_q_t s;
    flush();
    s = '{8'h00, 8'hAA, 8'hFF, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    send_stream(s);
    wait_words(1, 50);
    #2;
    reset_n_i = 1'b0;
    #1;
    tests += 4;
    if (busy !== 1'b0)     begin fails++; $display("FAIL arst_busy: got %b, required 0", busy); end
    if (count !== 16'd0)   begin fails++; $display("FAIL arst_count: got %0d, required 0", count); end
    if (wdata !== 32'h0)   begin fails++; $display("FAIL arst_data: got %h, required 0", wdata); end
    if (fsm_state !== 3'd0) begin fails++; $display("FAIL arst_state: got %0d, required 0", fsm_state); end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    got_q.delete();
  endtask

  task automatic test_width2();
    byte_q_t s;
    int c;
    @(negedge clk_i);
    dfu_mode = 1'b0;
    dfu_mode2 = 1'b1;
    cfg_ready = 1'b1;
    tgt = 1;
    got2_q.delete();
    s = '{8'h00, 8'hAA, 8'hFF, 8'h01, 8'hCA, 8'hFE};
    send_stream(s);
    c = 0;
    while (got2_q.size() < 1 && c < 50) begin @(negedge clk_i); c++; end
    repeat (5) @(negedge clk_i);
    tests += 3;
    if (got2_q.size() != 1) begin fails++; $display("FAIL w2_total: got %0d, required 1", got2_q.size()); end
    if (got2_q.size() > 0 && got2_q[0] !== 16'hCAFE) begin fails++; $display("FAIL w2_word: got %h, required cafe", got2_q[0]); end
    if (count2 !== 16'd1) begin fails++; $display("FAIL w2_count: got %0d, required 1", count2); end
    tgt = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    test_reset();
    dfu_mode = 1'b1;
    test_basic();
    test_error();
    test_resync();
    test_back_to_back();
    test_alt_flush();
    test_random();
    test_reset_midframe();
    test_width2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
